// File: rtl/rx_byte_arbiter.sv
// rx_byte_arbiter: round-robin merge of NUM_CH receiver byte pulses
// into one valid/ready byte stream, tagged with the source channel.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   rx_done         per-channel one-cycle byte-valid pulses
//   rx_byte         channel i byte on [8i+7:8i]
//   o_valid/o_byte  output beat, o_ch = source channel
//   i_ready         consumer accepts when o_valid & i_ready
//   o_ovr           sticky per-channel overrun, cleared by i_ovr_clr
//   o_drop_cnt      saturating count of dropped bytes
module rx_byte_arbiter #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     rx_done,
    input  logic [8*NUM_CH-1:0]   rx_byte,
    output logic                  o_valid,
    output logic [7:0]            o_byte,
    output logic [CH_W-1:0]       o_ch,
    input  logic                  i_ready,
    output logic [NUM_CH-1:0]     o_ovr,
    input  logic [NUM_CH-1:0]     i_ovr_clr,
    output logic [7:0]            o_drop_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]        state;
    logic [NUM_CH-1:0] slot_full;
    logic [7:0]        slot_data [NUM_CH];
    logic [CH_W-1:0]   last_grant;

    logic              out_free;
    logic              found;
    logic              grant;
    logic [CH_W-1:0]   win;
    logic [NUM_CH-1:0] drop;
    logic [CH_W:0]     n_drop;
    logic [8:0]        cnt_sum;

    assign o_valid  = (state == ST_HOLD);
    assign out_free = (state == ST_EMPTY) || i_ready;

    // First full slot after last_grant, with wrap.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_grant) + k) % NUM_CH;
            if (!found && slot_full[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        grant = found && out_free;
    end

    // A full slot being granted this cycle can take a new byte
    // without losing anything; otherwise a pulse on a full slot drops.
    always_comb begin
        drop   = '0;
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop[i] = rx_done[i] && slot_full[i]
                      && !(grant && win == CH_W'(i));
            n_drop  = n_drop + {{CH_W{1'b0}}, drop[i]};
        end
        cnt_sum = {1'b0, o_drop_cnt} + 9'(n_drop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full <= '0;
            for (int i = 0; i < NUM_CH; i++) slot_data[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (rx_done[i] && !drop[i]) begin
                    slot_data[i] <= rx_byte[8*i +: 8];
                    slot_full[i] <= 1'b1;
                end else if (grant && win == CH_W'(i)) begin
                    slot_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_EMPTY;
            o_byte     <= '0;
            o_ch       <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else if (grant) begin
            state      <= ST_HOLD;
            o_byte     <= slot_data[win];
            o_ch       <= win;
            last_grant <= win;
        end else if (state == ST_HOLD && i_ready) begin
            state <= ST_EMPTY;
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ovr      <= '0;
            o_drop_cnt <= '0;
        end else begin
            o_ovr      <= (o_ovr & ~i_ovr_clr) | drop;
            o_drop_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

endmodule

// File: tb/tb_rx_byte_arbiter.sv
// Self-checking bench for rx_byte_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_rx_byte_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] rx_done;
    logic [8*N-1:0] rx_byte;
    logic         o_valid;
    logic [7:0]   o_byte;
    logic [1:0]   o_ch;
    logic         i_ready;
    logic [N-1:0] o_ovr;
    logic [N-1:0] i_ovr_clr;
    logic [7:0]   o_drop_cnt;

    int tests = 0;
    int fails = 0;

    rx_byte_arbiter #(.NUM_CH(N)) dut (
        .clk(clk), .rst(rst),
        .rx_done(rx_done), .rx_byte(rx_byte),
        .o_valid(o_valid), .o_byte(o_byte), .o_ch(o_ch),
        .i_ready(i_ready),
        .o_ovr(o_ovr), .i_ovr_clr(i_ovr_clr),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rx_done   = '0;
        rx_byte   = '0;
        i_ready   = 1'b0;
        i_ovr_clr = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if ({o_valid, o_byte, o_ch, o_ovr, o_drop_cnt} !== '0) begin
            fails++;
            $display("FAIL reset: v=%b b=%h ch=%0d ovr=%b cnt=%0d want 0",
                     o_valid, o_byte, o_ch, o_ovr, o_drop_cnt);
        end
    endtask

    task automatic test_single;
        do_reset();
        i_ready = 1'b1;
        rx_done = 4'b0001;
        rx_byte[7:0] = 8'h55;
        tick();
        rx_done = '0;
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early: o_valid=%b want 0", o_valid);
        end
        tick();
        tests++;
        if ({o_valid, o_byte, o_ch} !== {1'b1, 8'h55, 2'd0}) begin
            fails++;
            $display("FAIL single_beat: v=%b b=%h ch=%0d want 1 55 0",
                     o_valid, o_byte, o_ch);
        end
        tick();
        tests++;
        if ({o_valid, o_ovr, o_drop_cnt} !== '0) begin
            fails++;
            $display("FAIL single_after: v=%b ovr=%b cnt=%0d want 0 0 0",
                     o_valid, o_ovr, o_drop_cnt);
        end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp_b;
        do_reset();
        i_ready = 1'b1;
        rx_done = 4'hF;
        rx_byte = 32'h44332211;
        tick();
        rx_done = '0;
        for (int c = 0; c < N; c++) begin
            tick();
            exp_b = 8'(8'h11 * (c + 1));
            tests++;
            if ({o_valid, o_byte, o_ch} !== {1'b1, exp_b, 2'(c)}) begin
                fails++;
                $display("FAIL simul_beat%0d: v=%b b=%h ch=%0d want 1 %h %0d",
                         c, o_valid, o_byte, o_ch, exp_b, c);
            end
        end
        tick();
        tests++;
        if ({o_valid, o_drop_cnt} !== 9'd0) begin
            fails++;
            $display("FAIL simul_end: v=%b cnt=%0d want 0 0",
                     o_valid, o_drop_cnt);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        rx_done = 4'b0010;
        rx_byte[15:8] = 8'hAA;
        tick();
        rx_done = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++;
            if ({o_valid, o_byte, o_ch} !== {1'b1, 8'hAA, 2'd1}) begin
                fails++;
                $display("FAIL bp_hold%0d: v=%b b=%h ch=%0d want 1 aa 1",
                         i, o_valid, o_byte, o_ch);
            end
            tick();
        end
        i_ready = 1'b1;
        tick();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_overrun;
        do_reset();
        rx_done = 4'b0100; rx_byte[23:16] = 8'h01; tick();
        rx_done = '0; tick();
        rx_done = 4'b0100; rx_byte[23:16] = 8'h02; tick();
        rx_done = '0; tick();
        rx_done = 4'b0100; rx_byte[23:16] = 8'h03; tick();
        rx_done = '0;
        tests++;
        if ({o_ovr, o_drop_cnt} !== {4'b0100, 8'd1}) begin
            fails++;
            $display("FAIL ovr_set: ovr=%b cnt=%0d want 0100 1",
                     o_ovr, o_drop_cnt);
        end
        tests++;
        if ({o_valid, o_byte, o_ch} !== {1'b1, 8'h01, 2'd2}) begin
            fails++;
            $display("FAIL ovr_first: v=%b b=%h ch=%0d want 1 01 2",
                     o_valid, o_byte, o_ch);
        end
        i_ready = 1'b1;
        tick();
        tests++;
        if ({o_valid, o_byte, o_ch} !== {1'b1, 8'h02, 2'd2}) begin
            fails++;
            $display("FAIL ovr_second: v=%b b=%h ch=%0d want 1 02 2",
                     o_valid, o_byte, o_ch);
        end
        tick();
        tests++;
        if (o_valid !== 1'b0) begin
            fails++;
            $display("FAIL ovr_drain: o_valid=%b want 0", o_valid);
        end
        i_ovr_clr = 4'b0100;
        tick();
        i_ovr_clr = '0;
        tests++;
        if ({o_ovr, o_drop_cnt} !== {4'b0000, 8'd1}) begin
            fails++;
            $display("FAIL ovr_clear: ovr=%b cnt=%0d want 0000 1",
                     o_ovr, o_drop_cnt);
        end
    endtask

    task automatic test_fairness_sat;
        logic [1:0] exp_ch;
        do_reset();
        i_ready = 1'b1;
        rx_done = 4'b1001;
        rx_byte = 32'hC3_00_00_A0;
        tick();
        exp_ch = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if ({o_valid, o_ch} !== {1'b1, exp_ch}) begin
                fails++;
                $display("FAIL fair%0d: v=%b ch=%0d want 1 %0d",
                         i, o_valid, o_ch, exp_ch);
            end
            exp_ch = (exp_ch == 2'd0) ? 2'd3 : 2'd0;
        end
        i_ready = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        tests++;
        if (o_drop_cnt !== 8'd255) begin
            fails++;
            $display("FAIL drop_sat: cnt=%0d want 255", o_drop_cnt);
        end
        tests++;
        if (o_ovr !== 4'b1001) begin
            fails++;
            $display("FAIL sat_ovr: ovr=%b want 1001", o_ovr);
        end
        rx_done = '0;
    endtask

    task automatic test_reset_midop;
        do_reset();
        rx_done = 4'b0011;
        rx_byte = 32'h00_00_B1_B0;
        tick();
        rx_done = 4'b0100;
        rx_byte[23:16] = 8'hB2;
        tick();
        rx_done = '0;
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL midop_setup: o_valid=%b want 1", o_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({o_valid, o_byte, o_ch, o_ovr, o_drop_cnt} !== '0) begin
            fails++;
            $display("FAIL midop_async: v=%b b=%h ch=%0d ovr=%b cnt=%0d want 0",
                     o_valid, o_byte, o_ch, o_ovr, o_drop_cnt);
        end
        tick();
        rst = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL midop_stale%0d: v=%b b=%h want 0",
                         i, o_valid, o_byte);
            end
        end
        rx_done = 4'b0001;
        rx_byte[7:0] = 8'h5A;
        tick();
        rx_done = '0;
        tick();
        tests++;
        if ({o_valid, o_byte, o_ch} !== {1'b1, 8'h5A, 2'd0}) begin
            fails++;
            $display("FAIL midop_new: v=%b b=%h ch=%0d want 1 5a 0",
                     o_valid, o_byte, o_ch);
        end
    endtask

    // Reference model: each channel holds at most one pending byte;
    // a free output takes the next pending channel in rotation.
    task automatic test_random;
        bit         m_full [N];
        logic [7:0] m_data [N];
        bit         n_full [N];
        logic [7:0] n_data [N];
        bit         m_valid;
        logic [7:0] m_byte;
        logic [1:0] m_ch;
        int         m_last;
        logic [N-1:0] m_ovr;
        logic [N-1:0] set;
        int         m_cnt;
        int         win;
        int         drops;
        int         c;
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0;
            m_data[i] = '0;
        end
        m_valid = 0; m_byte = '0; m_ch = '0;
        m_last = N - 1; m_ovr = '0; m_cnt = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rx_done = 4'($urandom & $urandom);
            if (cyc > 1000) rx_done = rx_done & 4'($urandom);
            rx_byte = 32'($urandom);
            i_ready = ($urandom_range(0, 3) != 0);
            i_ovr_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;

            win = -1;
            if (!m_valid || i_ready) begin
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (win < 0 && m_full[c]) win = c;
                end
            end
            drops = 0;
            set = '0;
            for (int ch = 0; ch < N; ch++) begin
                n_full[ch] = m_full[ch];
                n_data[ch] = m_data[ch];
                if (ch == win) n_full[ch] = 0;
                if (rx_done[ch]) begin
                    if (!m_full[ch] || ch == win) begin
                        n_full[ch] = 1;
                        n_data[ch] = rx_byte[8*ch +: 8];
                    end else begin
                        drops++;
                        set[ch] = 1'b1;
                    end
                end
            end
            if (win >= 0) begin
                m_valid = 1;
                m_byte  = m_data[win];
                m_ch    = 2'(win);
                m_last  = win;
            end else if (m_valid && i_ready) begin
                m_valid = 0;
            end
            for (int ch = 0; ch < N; ch++) begin
                m_full[ch] = n_full[ch];
                m_data[ch] = n_data[ch];
            end
            m_ovr = (m_ovr & ~i_ovr_clr) | set;
            m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;

            tick();
            tests++;
            if ({o_valid, o_byte, o_ch, o_ovr, o_drop_cnt} !==
                {m_valid, m_byte, m_ch, m_ovr, 8'(m_cnt)}) begin
                fails++;
                $display("FAIL rand%0d: got v=%b b=%h ch=%0d ovr=%b cnt=%0d want v=%b b=%h ch=%0d ovr=%b cnt=%0d",
                         cyc, o_valid, o_byte, o_ch, o_ovr, o_drop_cnt,
                         m_valid, m_byte, m_ch, m_ovr, m_cnt);
            end
        end
        rx_done = '0;
        i_ovr_clr = '0;
    endtask

    initial begin
        rst = 1'b1;
        rx_done = '0;
        rx_byte = '0;
        i_ready = 1'b0;
        i_ovr_clr = '0;
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_overrun();
        test_fairness_sat();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_byte_arbiter.md
# rx_byte_arbiter

Round-robin arbiter that merges the byte outputs of NUM_CH parallel serial receivers into one valid/ready byte stream. Each receiver presents a one-cycle done pulse with a parity-checked byte. The arbiter buffers one byte per channel, grants channels fairly to a single downstream consumer, and tags each byte with its source channel. It sits between the receiver array and the packet or host logic, and it reports per-channel overruns when a receiver delivers faster than the consumer drains.

## Interface
- NUM_CH, 4, number of receiver channels (≥2); CH_W = $clog2(NUM_CH) is derived
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_done  in  NUM_CH  per-channel byte-valid pulse; each high cycle is one new byte
- rx_byte  in  8*NUM_CH  channel i byte on bits [8i+7:8i], sampled only when rx_done[i]=1
- o_valid  out  1  output byte valid
- o_byte  out  8  output byte
- o_ch  out  CH_W  source channel of o_byte
- i_ready  in  1  consumer accepts o_byte when o_valid&i_ready
- o_ovr  out  NUM_CH  sticky per-channel overrun flags
- i_ovr_clr  in  NUM_CH  per-channel overrun clear
- o_drop_cnt  out  8  saturating count of dropped bytes, all channels

## Operation
- Per-channel slot holds slot_full[i] and slot_data[i].
- The output register has two states:
  - EMPTY: o_valid=0.
  - HOLD: o_valid=1.
  - HOLD→EMPTY on accept with no new grant. Otherwise a grant reloads it.
- Grant condition: the output register is free, meaning EMPTY or (HOLD & i_ready), and at least one slot is full.
- Winner is the first full slot searching from (last_grant+1) mod NUM_CH upward with wrap.
- On grant:
  - o_byte and o_ch load from the winner, and o_valid=1 next cycle.
  - The winner's slot clears.
  - last_grant is set to the winner.
- Slot capture when rx_done[i]=1:
  - Slot empty: load byte, set full.
  - Slot full and granted this cycle: load new byte, full stays 1. This is not an overrun.
  - Slot full and not granted: new byte dropped, old byte kept. o_ovr[i] sets and o_drop_cnt increments.
- o_drop_cnt saturates at 255. When several channels drop in the same cycle, it increments by the number of drops, saturated.
- o_ovr[i] clears when i_ovr_clr[i]=1. If a set and a clear hit the same cycle, the set wins.
- While o_valid=1 and i_ready=0, o_byte and o_ch stay stable.

## Timing
- Reset values:
  - o_valid=0, o_byte=0, o_ch=0
  - o_ovr=0, o_drop_cnt=0
  - all slot_full=0, last_grant=NUM_CH-1, so channel 0 has first priority
- Reset asserted mid-operation discards all buffered bytes immediately, with no output beat.
- Latency: rx_done sampled at edge k puts the slot full after k. With the output free, o_valid=1 after edge k+1. Minimum latency is 2 cycles and there is no bypass path.
- Throughput: one byte per cycle when i_ready is held high and slots stay full.
- Fairness: with all channels continuously full, grants rotate 0,1,…,NUM_CH-1,0. No channel waits more than NUM_CH grants.
- rx_done bits and i_ovr_clr are level-sampled each cycle. Back-to-back pulses on one channel are legal.

## Test plan
- Single byte: rx_done[0] for 1 cycle with 0x55, i_ready=1.
  - o_valid high exactly 1 cycle, 2 cycles later, with o_byte=0x55 and o_ch=0.
  - o_ovr=0, o_drop_cnt=0.
- Simultaneous: rx_done=4'b1111 with bytes 0x11,0x22,0x33,0x44 on ch0..3, i_ready=1.
  - Four consecutive beats: (0x11,0),(0x22,1),(0x33,2),(0x44,3).
  - No drops.
- Backpressure: ch1 byte 0xAA, i_ready=0 for 5 cycles, then 1.
  - o_valid=1 with o_byte=0xAA and o_ch=1 stable throughout.
  - Accepted on the first ready cycle, then o_valid=0.
- Overrun: i_ready=0; ch2 sends 0x01, then 0x02 and 0x03 on later cycles. Output register takes 0x01 and the slot takes 0x02.
  - 0x03 is dropped: o_ovr[2]=1, o_drop_cnt=1.
  - After i_ready=1, outputs 0x01 then 0x02.
  - Pulse i_ovr_clr[2]: o_ovr[2]=0.
- Fairness and saturation: ch0 and ch3 pulse rx_done every cycle, i_ready=1.
  - Grants alternate 0,3,0,3.
  - With i_ready=0 for 300 cycles, o_drop_cnt stops at 255.
- Reset mid-operation: assert rst with o_valid=1 and two full slots.
  - All outputs go to reset values asynchronously.
  - After release, no stale bytes appear and the first new ch0 byte arrives in 2 cycles.
